mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_pkg.sv | 23 ++
 rtl/be_lane_mux.sv | 49 ++++
 rtl/mem_access_unit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// Shared types for the byte-addressable load/store unit.
// Access-size encoding, FSM state codes and lane masks.
package mem_access_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10,
      SZ_X = 2'b11
   } size_e;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE = 3'd0;
   localparam state_t ST_RD   = 3'd1;
   localparam state_t ST_CAP  = 3'd2;
   localparam state_t ST_WR   = 3'd3;
   localparam state_t ST_RESP = 3'd4;

   localparam logic [31:0] BYTE_MASK = 32'h0000_00FF;
   localparam logic [31:0] HALF_MASK = 32'h0000_FFFF;

endpackage

// File: rtl/be_lane_mux.sv
// Big-endian lane extract/extend (loads) and lane merge (stores).
// Ports: rd_word/base_word/wdata in, size/is_unsigned/offset in, load_data/merge_data out.
module be_lane_mux
   import mem_access_pkg::*;
(
   input  logic [31:0] rd_word,
   input  logic [31:0] base_word,
   input  logic [31:0] wdata,
   input  size_e       size,
   input  logic        is_unsigned,
   input  logic [1:0]  offset,
   output logic [31:0] load_data,
   output logic [31:0] merge_data
);

   // Byte at offset k sits at bit 24-8k, so the shift is 8*(3-k) = {~k,000}.
   logic [4:0] b_sh;
   logic [4:0] h_sh;
   logic [7:0] byte_v;
   logic [15:0] half_v;

   always_comb begin
      b_sh       = {~offset, 3'b000};
      h_sh       = {~offset[1], 4'b0000};
      byte_v     = 8'(rd_word >> b_sh);
      half_v     = 16'(rd_word >> h_sh);
      load_data  = rd_word;
      merge_data = wdata;
      unique case (size)
         SZ_B: begin
            load_data  = is_unsigned ? {24'b0, byte_v}
                                     : {{24{byte_v[7]}}, byte_v};
            merge_data = (base_word & ~(BYTE_MASK << b_sh))
                       | ((wdata & BYTE_MASK) << b_sh);
         end
         SZ_H: begin
            load_data  = is_unsigned ? {16'b0, half_v}
                                     : {{16{half_v[15]}}, half_v};
            merge_data = (base_word & ~(HALF_MASK << h_sh))
                       | ((wdata & HALF_MASK) << h_sh);
         end
         default: begin
            load_data  = rd_word;
            merge_data = wdata;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit in front of a big-endian word memory with 1-cycle read.
// Ports: req_* handshake in, rsp_* completion out, mem_A/WD/MemWrite/RD to memory.
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int unsigned MEM_BYTES = 1024
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] mem_A,
   output logic [31:0] mem_WD,
   output logic        mem_MemWrite,
   input  logic [31:0] mem_RD
);

   state_t      state;
   logic        op_write;
   logic        op_unsigned;
   size_e       op_size;
   logic [31:0] op_addr;
   logic [31:0] op_wdata;
   logic [31:0] cap_word;
   logic [31:0] load_data;
   logic [31:0] merge_data;
   logic [31:0] req_base;
   logic        req_err;
   logic        align_err;

   always_comb begin
      req_base  = {req_addr[31:2], 2'b00};
      align_err = 1'b0;
      unique case (size_e'(req_size))
         SZ_H:    align_err = req_addr[0];
         SZ_W:    align_err = |req_addr[1:0];
         SZ_X:    align_err = 1'b1;
         default: align_err = 1'b0;
      endcase
      req_err = align_err
              | ((req_base + 32'd3) >= 32'(MEM_BYTES));
   end

   be_lane_mux u_lane (
      .rd_word     (mem_RD),
      .base_word   (cap_word),
      .wdata       (op_wdata),
      .size        (op_size),
      .is_unsigned (op_unsigned),
      .offset      (op_addr[1:0]),
      .load_data   (load_data),
      .merge_data  (merge_data)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         op_write    <= 1'b0;
         op_unsigned <= 1'b0;
         op_size     <= SZ_B;
         op_addr     <= '0;
         op_wdata    <= '0;
         cap_word    <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  op_write    <= req_write;
                  op_unsigned <= req_unsigned;
                  op_size     <= size_e'(req_size);
                  op_addr     <= req_addr;
                  op_wdata    <= req_wdata;
                  if (req_err) begin
                     state     <= ST_RESP;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= '0;
                  end else if (req_write && req_size == SZ_W) begin
                     state <= ST_WR;
                  end else begin
                     state <= ST_RD;
                  end
               end
            end
            ST_RD: state <= ST_CAP;
            ST_CAP: begin
               cap_word <= mem_RD;
               if (op_write) begin
                  state <= ST_WR;
               end else begin
                  state     <= ST_RESP;
                  rsp_rdata <= load_data;
                  rsp_err   <= 1'b0;
               end
            end
            ST_WR: begin
               state     <= ST_RESP;
               rsp_rdata <= '0;
               rsp_err   <= 1'b0;
            end
            ST_RESP: begin
               state     <= ST_IDLE;
               rsp_rdata <= '0;
               rsp_err   <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      req_ready    = (state == ST_IDLE);
      rsp_valid    = (state == ST_RESP);
      mem_A        = '0;
      if (state == ST_RD || state == ST_CAP || state == ST_WR)
         mem_A = {op_addr[31:2], 2'b00};
      // Reset gates the strobe so a reset landing in WR never writes.
      mem_MemWrite = (state == ST_WR) & rst_n;
      mem_WD       = (state == ST_WR) ? merge_data : '0;
   end

endmodule
